// File: rtl/trace_fmt_pkg.sv
// Shared constants, FSM encoding and ASCII helpers for the trace formatter.
package trace_fmt_pkg;

  localparam logic [7:0] CH_CARET  = 8'h5e;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3a;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2a;
  localparam logic [7:0] CH_LT     = 8'h3c;
  localparam logic [7:0] CH_EQ     = 8'h3d;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_A      = 8'h61;

  localparam logic [13:0] TIME_MAX = 14'd9999;

  typedef enum logic [3:0] {
    S_IDLE, S_CONV, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SPC1,
    S_TAG, S_OPND, S_SPC2, S_LT, S_EQ, S_SPC3, S_DATA, S_HASH
  } state_t;

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (CH_ZERO + {4'd0, n}) : (CH_A + {4'd0, n} - 8'd10);
  endfunction

  function automatic logic [7:0] dec2ascii(input logic [3:0] d);
    return CH_ZERO + {4'd0, d};
  endfunction

  // Index 0 selects the most significant nibble of the word.
  function automatic logic [3:0] nib_sel(input logic [31:0] w, input logic [2:0] i);
    return w[{~i, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/trace_formatter_bin2bcd.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift/add-3), 14 steps after start.
module bin2bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  logic [13:0] r_bin;
  logic [15:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_done;
  logic [15:0] w_adj;

  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? (r_bcd[gi*4 +: 4] + 4'd3)
                                                         : r_bcd[gi*4 +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_bin <= bin;
        r_bcd <= '0;
        r_cnt <= 4'd14;
      end else if (r_cnt != 4'd0) begin
        {r_bcd, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
        r_cnt          <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) r_done <= 1'b1;
      end
    end
  end

  assign bcd  = r_bcd;
  assign done = r_done;

endmodule

// File: rtl/trace_formatter.sv
// Serialises one write-back trace record into an ASCII character stream over valid/ready.
module trace_formatter
  import trace_fmt_pkg::*;
#(
  parameter int SPACES_AFTER_COLON = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_kind,
  input  logic [13:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy,
  output logic        rec_done
);

  localparam bit         SP_NONE = (SPACES_AFTER_COLON == 0);
  localparam logic [2:0] SP_LAST = 3'(SPACES_AFTER_COLON - 1);

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [7:0]  r_char;
  logic        r_rec_done;
  logic        r_kind;
  logic [31:0] r_pc;
  logic [4:0]  r_reg;
  logic [31:0] r_addr;
  logic [31:0] r_data;

  state_t      w_state_next;
  logic [2:0]  w_idx_next;
  logic [7:0]  w_char_next;
  logic        w_accept;
  logic        w_xfer;
  logic [13:0] w_time_sat;
  logic [15:0] w_bcd;
  logic        w_bcd_done;
  logic [2:0]  w_time_first;
  logic [3:0]  w_time_digit;
  logic [3:0]  w_tens;
  logic [3:0]  w_ones;

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = !in_ready;
  assign char_valid = (r_state != S_IDLE) && (r_state != S_CONV);
  assign char_out   = r_char;
  assign rec_done   = r_rec_done;
  assign w_accept   = in_valid && in_ready;
  assign w_xfer     = char_valid && char_ready;
  assign w_time_sat = (in_time > TIME_MAX) ? TIME_MAX : in_time;

  bin2bcd u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (w_accept),
    .bin   (w_time_sat),
    .bcd   (w_bcd),
    .done  (w_bcd_done)
  );

  // Leading-zero suppression: start the digit index at the first non-zero BCD digit.
  assign w_time_first = (w_bcd[15:12] != 4'd0) ? 3'd0 :
                        (w_bcd[11:8]  != 4'd0) ? 3'd1 :
                        (w_bcd[7:4]   != 4'd0) ? 3'd2 : 3'd3;
  assign w_time_digit = w_bcd[{~w_idx_next[1:0], 2'b00} +: 4];

  always_comb begin
    if (r_reg >= 5'd30) begin
      w_tens = 4'd3;
      w_ones = 4'(r_reg - 5'd30);
    end else if (r_reg >= 5'd20) begin
      w_tens = 4'd2;
      w_ones = 4'(r_reg - 5'd20);
    end else if (r_reg >= 5'd10) begin
      w_tens = 4'd1;
      w_ones = 4'(r_reg - 5'd10);
    end else begin
      w_tens = 4'd0;
      w_ones = 4'(r_reg);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_CONV;
      S_CONV: if (w_bcd_done) w_state_next = S_CARET;
      default: begin
        if (w_xfer) begin
          w_idx_next = r_idx + 3'd1;
          case (r_state)
            S_CARET: begin w_state_next = S_TIME; w_idx_next = w_time_first; end
            S_TIME:  if (r_idx == 3'd3) w_state_next = S_AT;
            S_AT:    begin w_state_next = S_PC; w_idx_next = 3'd0; end
            S_PC:    if (r_idx == 3'd7) w_state_next = S_COLON;
            S_COLON: begin w_state_next = SP_NONE ? S_TAG : S_SPC1; w_idx_next = 3'd0; end
            S_SPC1:  if (r_idx == SP_LAST) w_state_next = S_TAG;
            S_TAG: begin
              w_state_next = S_OPND;
              w_idx_next   = (r_kind || w_tens != 4'd0) ? 3'd0 : 3'd1;
            end
            S_OPND:  if (r_kind ? (r_idx == 3'd7) : (r_idx == 3'd1)) w_state_next = S_SPC2;
            S_SPC2:  w_state_next = S_LT;
            S_LT:    w_state_next = S_EQ;
            S_EQ:    w_state_next = S_SPC3;
            S_SPC3:  begin w_state_next = S_DATA; w_idx_next = 3'd0; end
            S_DATA:  if (r_idx == 3'd7) w_state_next = S_HASH;
            default: w_state_next = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    w_char_next = 8'h00;
    case (w_state_next)
      S_CARET: w_char_next = CH_CARET;
      S_TIME:  w_char_next = dec2ascii(w_time_digit);
      S_AT:    w_char_next = CH_AT;
      S_PC:    w_char_next = nib2hex(nib_sel(r_pc, w_idx_next));
      S_COLON: w_char_next = CH_COLON;
      S_SPC1, S_SPC2, S_SPC3: w_char_next = CH_SPACE;
      S_TAG:   w_char_next = r_kind ? CH_STAR : CH_DOLLAR;
      S_OPND:  w_char_next = r_kind ? nib2hex(nib_sel(r_addr, w_idx_next))
                                    : dec2ascii((w_idx_next == 3'd0) ? w_tens : w_ones);
      S_LT:    w_char_next = CH_LT;
      S_EQ:    w_char_next = CH_EQ;
      S_DATA:  w_char_next = nib2hex(nib_sel(r_data, w_idx_next));
      S_HASH:  w_char_next = CH_HASH;
      default: w_char_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_char     <= '0;
      r_rec_done <= 1'b0;
      r_kind     <= 1'b0;
      r_pc       <= '0;
      r_reg      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_char     <= w_char_next;
      r_rec_done <= w_xfer && (r_state == S_HASH);
      if (w_accept) begin
        r_kind <= in_kind;
        r_pc   <= in_pc;
        r_reg  <= in_reg;
        r_addr <= in_addr;
        r_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_trace_formatter.sv
// Scoreboard bench for trace_formatter: expected strings are queued at issue, a monitor checks each transfer.
module tb_trace_formatter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_valid0 = 1'b0;
  logic        in_kind = 1'b0;
  logic [13:0] in_time = '0;
  logic [31:0] in_pc = '0, in_addr = '0, in_data = '0;
  logic [4:0]  in_reg = '0;
  logic        char_ready = 1'b1;
  logic        in_ready, char_valid, busy, rec_done;
  logic [7:0]  char_out;
  logic        in_ready0, char_valid0, busy0, rec_done0;
  logic [7:0]  char_out0;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [7:0] q0[$];

  always #5 clk = ~clk;

  trace_formatter #(.SPACES_AFTER_COLON(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_time(in_time), .in_pc(in_pc), .in_reg(in_reg),
    .in_addr(in_addr), .in_data(in_data), .char_out(char_out),
    .char_valid(char_valid), .char_ready(char_ready), .busy(busy), .rec_done(rec_done)
  );

  trace_formatter #(.SPACES_AFTER_COLON(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_kind(in_kind), .in_time(in_time), .in_pc(in_pc), .in_reg(in_reg),
    .in_addr(in_addr), .in_data(in_data), .char_out(char_out0),
    .char_valid(char_valid0), .char_ready(1'b1), .busy(busy0), .rec_done(rec_done0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected character per accepted transfer.
  bit in_rec = 0, pend_done = 0, pend_done0 = 0;
  int bubbles = 0;
  always @(negedge clk) begin
    if (reset) begin
      in_rec = 0; pend_done = 0; pend_done0 = 0; bubbles = 0;
    end else begin
      if (pend_done) begin
        check("rec_done_pulse", {30'd0, rec_done, char_valid}, 32'h2);
        pend_done = 0;
      end else if (rec_done) begin
        check("rec_done_spurious", {31'd0, rec_done}, 32'd0);
      end
      if (in_rec && !char_valid) bubbles++;
      if (char_valid && char_ready) begin
        if (q.size() == 0) begin
          check("unexpected_char", {24'd0, char_out}, 32'h0);
        end else begin
          logic [7:0] e;
          e = q.pop_front();
          check("char", {24'd0, char_out}, {24'd0, e});
        end
        in_rec = 1;
        if (char_out == 8'h23) begin
          check("no_bubble", bubbles, 0);
          in_rec = 0; bubbles = 0; pend_done = 1;
        end
      end
      if (pend_done0) begin
        check("rec_done0_pulse", {31'd0, rec_done0}, 32'd1);
        pend_done0 = 0;
      end
      if (char_valid0) begin
        if (q0.size() == 0) begin
          check("unexpected_char0", {24'd0, char_out0}, 32'h0);
        end else begin
          logic [7:0] e0;
          e0 = q0.pop_front();
          check("char_sp0", {24'd0, char_out0}, {24'd0, e0});
        end
        if (char_out0 == 8'h23) pend_done0 = 1;
      end
      $display("cyc char=%h v=%0d rdy=%0d done=%0d | char0=%h v0=%0d", char_out, char_valid,
               char_ready, rec_done, char_out0, char_valid0);
    end
  end

  task automatic set_fields(input bit kind, input [13:0] t, input [31:0] pc, input [4:0] rg,
                            input [31:0] addr, input [31:0] data);
    in_kind = kind; in_time = t; in_pc = pc; in_reg = rg; in_addr = addr; in_data = data;
  endtask

  task automatic push_str(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (sel) q0.push_back(s[i]);
      else q.push_back(s[i]);
    end
  endtask

  // Issue a record and return #1 after its accept edge; in_valid is left high when hold=1.
  task automatic send(input bit sel, input bit hold, input bit kind, input [13:0] t,
                      input [31:0] pc, input [4:0] rg, input [31:0] addr, input [31:0] data,
                      input string exp);
    bit acc, ok;
    push_str(sel, exp);
    set_fields(kind, t, pc, rg, addr, data);
    if (sel) in_valid0 = 1'b1; else in_valid = 1'b1;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      acc = sel ? in_ready0 : in_ready;
      @(posedge clk); #1;
      if (acc) begin ok = 1; break; end
    end
    if (!hold) begin in_valid = 1'b0; in_valid0 = 1'b0; end
    check("accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && q0.size() == 0 && in_ready && in_ready0) begin ok = 1; break; end
    end
    check("drain_timeout", {31'd0, ok}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_char_out", {24'd0, char_out}, 32'h00);
    check("reset_char_valid", {31'd0, char_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rec_done", {31'd0, rec_done}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Register record with first-character latency measurement.
    send(0, 0, 1'b0, 14'd5, 32'h00003000, 5'd3, 32'h0, 32'h0000abcd, "^5@00003000: $3 <= 0000abcd#");
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0;
    while (!char_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("first_char_latency", n, 15);
    wait_done();

    send(0, 0, 1'b1, 14'd1234, 32'h00400010, 5'd0, 32'h10000004, 32'hdeadbeef,
         "^1234@00400010: *10000004 <= deadbeef#");
    wait_done();
    send(0, 0, 1'b0, 14'd0, 32'h12345678, 5'd0, 32'h0, 32'h9abcdef0, "^0@12345678: $0 <= 9abcdef0#");
    wait_done();
    send(0, 0, 1'b0, 14'd12000, 32'hffffffff, 5'd31, 32'h0, 32'h00000001,
         "^9999@ffffffff: $31 <= 00000001#");
    wait_done();

    // Zero spaces after the colon.
    send(1, 0, 1'b0, 14'd7, 32'h00000abc, 5'd9, 32'h0, 32'h00000fff, "^7@00000abc:$9 <= 00000fff#");
    wait_done();

    // Backpressure on the 4th PC digit ('e' of cafef00d).
    send(0, 0, 1'b0, 14'd42, 32'hcafef00d, 5'd10, 32'h0, 32'h01234567, "^42@cafef00d: $10 <= 01234567#");
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(posedge clk); #1;
      if (char_valid && char_out == 8'h65) seen = 1;
    end
    check("bp_digit_seen", {31'd0, seen}, 32'd1);
    char_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("bp_stable", {23'd0, char_valid, char_out}, {23'd0, 1'b1, 8'h65});
    end
    char_ready = 1'b1;
    wait_done();

    // Reset in the middle of DATA, then a full record.
    send(0, 0, 1'b0, 14'd5, 32'h00003000, 5'd3, 32'h0, 32'h0000abcd, "^5@00003000: $3 <= 0000abcd#");
    repeat (36) @(posedge clk);
    #1;
    check("mid_data_valid", {31'd0, char_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    q.delete();
    check("rst_char_valid", {31'd0, char_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    send(0, 0, 1'b1, 14'd65, 32'h0badc0de, 5'd0, 32'h00000100, 32'h00c0ffee,
         "^65@0badc0de: *00000100 <= 00c0ffee#");
    wait_done();

    // in_valid held across two records; fields change while the first is busy.
    send(0, 1, 1'b0, 14'd300, 32'h0000beef, 5'd7, 32'h0, 32'h11111111, "^300@0000beef: $7 <= 11111111#");
    push_str(0, "^9999@80000000: *0000000f <= fedcba98#");
    repeat (5) @(posedge clk);
    #1;
    set_fields(1'b1, 14'd9999, 32'h80000000, 5'd2, 32'h0000000f, 32'hfedcba98);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk); #1;
      if (rec_done) seen = 1;
      else check("held_not_ready", {31'd0, in_ready}, 32'd0);
    end
    check("held_rec_done_seen", {31'd0, seen}, 32'd1);
    check("held_ready_in_done", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("held_second_accepted", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
